// File: rtl/photon_window_scheduler.sv
// photon_window_scheduler: settle delay, then a counted photon exposure window, then per-channel count readout.
module photon_window_scheduler #(
    parameter int N_CH = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 24,
    parameter int SET_W = 8,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SET_W-1:0] settle_len,
    input  logic [WIN_W-1:0] win_len,
    input  logic [N_CH-1:0]  pulse_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_data,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_sat,
    output logic             out_last,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DRAIN} state_t;
    state_t state, state_nxt;
    logic [SET_W-1:0] set_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [N_CH-1:0][CNT_W-1:0] cnt;
    logic [N_CH-1:0] sat;
    logic [CH_W-1:0] ch;
    logic last_ch, accept;

    assign last_ch   = ch == CH_W'(N_CH - 1);
    assign accept    = state == DRAIN && out_ready;
    assign busy      = state != IDLE;
    assign out_valid = state == DRAIN;
    assign out_ch    = ch;
    assign out_data  = out_valid ? cnt[ch] : '0;
    assign out_sat   = out_valid && sat[ch];
    assign out_last  = out_valid && last_ch;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = |settle_len ? SETTLE : |win_len ? COUNT : DRAIN;
            SETTLE:  if (set_cnt == SET_W'(1)) state_nxt = |win_cnt ? COUNT : DRAIN;
            COUNT:   if (win_cnt == WIN_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (out_ready && last_ch) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            set_cnt <= '0;
            win_cnt <= '0;
            cnt     <= '0;
            sat     <= '0;
            ch      <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= accept && last_ch && !abort;
            if (abort) begin
                cnt <= '0;
                sat <= '0;
                ch  <= '0;
            end else if (state == IDLE && start) begin
                set_cnt <= settle_len;
                win_cnt <= win_len;
                cnt     <= '0;
                sat     <= '0;
                ch      <= '0;
            end else if (state == SETTLE) begin
                set_cnt <= set_cnt - SET_W'(1);
            end else if (state == COUNT) begin
                win_cnt <= win_cnt - WIN_W'(1);
                // a full counter holds and flags saturation instead of wrapping
                for (int i = 0; i < N_CH; i++)
                    if (pulse_in[i]) begin
                        if (&cnt[i]) sat[i] <= 1'b1;
                        else cnt[i] <= cnt[i] + CNT_W'(1);
                    end
            end else if (accept) begin
                ch <= last_ch ? '0 : ch + CH_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_photon_window_scheduler.sv
// tb_photon_window_scheduler: directed checks of window timing, readout handshake, saturation and abort/reset.
module tb_photon_window_scheduler;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
    logic [7:0] settle_len = '0;
    logic [23:0] win_len = '0;
    logic [3:0] pulse_in = '0;
    logic busy, out_valid, out_sat, out_last, done;
    logic [3:0] out_data;
    logic [1:0] out_ch;
    logic [3:0] pat [0:63];
    int n_chk = 0, n_fail = 0;

    photon_window_scheduler #(.N_CH(4), .CNT_W(4), .WIN_W(24), .SET_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .settle_len(settle_len), .win_len(win_len), .pulse_in(pulse_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pat;
        for (int k = 0; k < 64; k++) pat[k] = '0;
    endtask

    // start at edge t; pat[k] drives pulse_in during cycle t+k; returns in cycle t+S+W+1
    task automatic window(input int s, input int w);
        out_ready = 0;
        pulse_in = '0;
        settle_len = 8'(s);
        win_len = 24'(w);
        start = 1;
        tick;
        start = 0;
        settle_len = 8'hff;
        win_len = 24'hffffff;
        for (int k = 1; k <= s + w; k++) begin
            pulse_in = pat[k];
            chk("win_busy", busy, 1);
            chk("win_valid", out_valid, 0);
            tick;
        end
        pulse_in = pat[s + w + 1];
        chk("first_valid", out_valid, 1);
    endtask

    // ends in the done cycle
    task automatic drain(input logic [15:0] rdy, input logic [15:0] exp_d, input logic [3:0] exp_s);
        int i = 0;
        for (int cyc = 0; cyc < 40 && i < 4; cyc++) begin
            out_ready = rdy[cyc % 16];
            chk("rec_valid", out_valid, 1);
            chk("rec_ch", out_ch, i);
            chk("rec_data", out_data, exp_d[i*4 +: 4]);
            chk("rec_sat", out_sat, exp_s[i]);
            chk("rec_last", out_last, i == 3);
            chk("rec_nodone", done, 0);
            tick;
            pulse_in = '0;
            if (out_ready) i++;
        end
        out_ready = 0;
        chk("drain_records", i, 4);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", out_valid, 0);
    endtask

    initial begin
        clear_pat;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        tick;
        rst_n = 1;
        tick;

        // basic: S=2 W=10, ch0 at COUNT 1,5,10; ch2 four times
        pat[3] = 4'b0001; pat[4] = 4'b0100; pat[5] = 4'b0100; pat[6] = 4'b0100;
        pat[7] = 4'b0001; pat[8] = 4'b0100; pat[12] = 4'b0001;
        window(2, 10);
        drain(16'hffff, 16'h0403, 4'b0000);
        tick;
        chk("done_once", done, 0);

        // edges: ch1 in last SETTLE and first DRAIN cycle, ch0 in first and last COUNT cycle
        clear_pat;
        pat[3] = 4'b0010; pat[4] = 4'b0001; pat[8] = 4'b0001; pat[9] = 4'b0010;
        window(3, 5);
        drain(16'hffff, 16'h0002, 4'b0000);
        tick;

        // backpressure: ready 0,0,1,0,1,1,...
        clear_pat;
        pat[2] = 4'b1111; pat[3] = 4'b1110; pat[4] = 4'b1100; pat[5] = 4'b1000;
        window(1, 4);
        drain(16'hfff4, 16'h4321, 4'b0000);
        tick;

        // saturation: ch0 exactly 15 pulses, ch3 20 pulses
        clear_pat;
        for (int k = 2; k <= 16; k++) pat[k] = 4'b1001;
        for (int k = 17; k <= 21; k++) pat[k] = 4'b1000;
        window(1, 20);
        drain(16'hffff, 16'hf00f, 4'b1000);
        tick;

        // zero window, ignored start while busy, start accepted in done cycle
        clear_pat;
        window(0, 0);
        start = 1;
        tick;
        start = 0;
        chk("busy_start_busy", busy, 1);
        chk("busy_start_ch", out_ch, 0);
        drain(16'hffff, 16'h0000, 4'b0000);
        settle_len = 0;
        win_len = 0;
        start = 1;
        tick;
        start = 0;
        chk("restart_valid", out_valid, 1);
        chk("restart_nodone", done, 0);
        drain(16'hffff, 16'h0000, 4'b0000);
        tick;
        chk("no_queue_busy", busy, 0);

        // abort during COUNT
        clear_pat;
        settle_len = 0;
        win_len = 10;
        start = 1;
        tick;
        start = 0;
        pulse_in = 4'b0001;
        tick; tick;
        abort = 1;
        tick;
        abort = 0;
        pulse_in = '0;
        chk("abort_cnt_busy", busy, 0);
        chk("abort_cnt_valid", out_valid, 0);
        chk("abort_cnt_done", done, 0);
        tick;
        chk("abort_cnt_done2", done, 0);

        // abort during DRAIN with ch1 stalled
        pat[1] = 4'b0010; pat[2] = 4'b0010;
        window(0, 2);
        out_ready = 1;
        tick;
        out_ready = 0;
        pulse_in = '0;
        chk("stall_ch", out_ch, 1);
        chk("stall_data", out_data, 2);
        tick;
        chk("stall_hold", out_ch, 1);
        abort = 1;
        tick;
        abort = 0;
        chk("abort_drn_valid", out_valid, 0);
        chk("abort_drn_busy", busy, 0);
        chk("abort_drn_done", done, 0);
        tick;
        chk("abort_drn_done2", done, 0);

        // start and abort together in IDLE
        start = 1;
        abort = 1;
        tick;
        start = 0;
        abort = 0;
        chk("abort_wins", busy, 0);

        // reset mid-COUNT, then a clean run
        settle_len = 0;
        win_len = 8;
        pulse_in = 4'b0100;
        start = 1;
        tick;
        start = 0;
        tick; tick;
        #2 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_done", done, 0);
        pulse_in = '0;
        tick;
        rst_n = 1;
        tick;
        clear_pat;
        pat[3] = 4'b0010;
        window(1, 3);
        drain(16'hffff, 16'h0010, 4'b0000);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/photon_window_scheduler.md
Name: photon_window_scheduler

Overview:
- Sequences photon-counting exposure windows for the single-pixel imaging path.
- Each start, typically from a DMD pattern-sync, runs a programmable settle delay, then an exposure window. During the window it counts single-cycle pulses from N_CH Pulse_Shaper outputs.
- After the window it drains the per-channel counts, one channel per handshake, to the readout/UART packer.

Parameters:
- N_CH, 4, number of pulse channels counted in parallel.
- CNT_W, 16, per-channel count width; counters saturate.
- WIN_W, 24, width of the window length (clock cycles).
- SET_W, 8, width of the settle length (clock cycles).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run one window; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE, discards counts, emits no output.
- settle_len  in  SET_W  settle cycles; sampled on accepted start.
- win_len  in  WIN_W  exposure cycles; sampled on accepted start.
- pulse_in  in  N_CH  single-cycle shaped pulses, one bit per channel.
- busy  out  1  high in any state other than IDLE.
- out_valid  out  1  count record valid.
- out_ready  in  1  consumer accepts the record when out_valid && out_ready.
- out_data  out  CNT_W  count for channel out_ch.
- out_ch  out  clog2(N_CH) (min 1)  channel index of the current record.
- out_sat  out  1  the reported counter saturated during the window.
- out_last  out  1  asserted with the record for channel N_CH-1.
- done  out  1  one-cycle pulse after the last record is accepted.

Behaviour:
- Reset (rst_n low, async): state IDLE; all counters 0; busy=0, out_valid=0, out_data=0, out_ch=0, out_sat=0, out_last=0, done=0.
- States:
  - IDLE: start at edge t latches settle_len/win_len, clears counters and sat flags, goes to SETTLE. If latched settle_len=0, it goes straight to COUNT.
  - SETTLE: runs exactly settle_len cycles. pulse_in is ignored. Then goes to COUNT.
  - COUNT: runs exactly win_len cycles. Each cycle, every channel with pulse_in[i]=1 increments count[i]. A pulse present in the first or last COUNT cycle is counted. Then goes to DRAIN. If latched win_len=0, COUNT is skipped and all counts report 0.
  - DRAIN: out_valid=1 from the cycle after the last COUNT cycle. Channels are reported in order 0..N_CH-1.
- Window timing, with start sampled at edge t:
  - settle_len=S, win_len=W.
  - COUNT cycles are t+1+S .. t+S+W.
  - First out_valid is at cycle t+S+W+1.
- Saturation: a counter at 2^CNT_W-1 holds its value and sets sat[i]. out_sat reports sat[out_ch].
- Handshake rules:
  - While out_valid && !out_ready, out_data/out_ch/out_sat/out_last hold stable.
  - On acceptance, the next channel's record is presented the following cycle (no bubble). Back-to-back acceptance gives one record per cycle.
  - out_valid never drops without acceptance, except on abort or reset.
- Completion: the cycle after the record with out_last is accepted, done=1 for one cycle, state is IDLE, out_valid=0, busy=0. A start in that same cycle is accepted.
- start outside IDLE is ignored; no queuing.
- abort has priority over start and over all state transitions. From any state it goes to IDLE the next cycle with out_valid=0 and no done. abort in IDLE is a no-op.
- If start and abort are both high in IDLE, abort wins and start is ignored.
- Reset mid-window or mid-drain: immediate IDLE, counts lost.
- win_len and settle_len changes while busy have no effect on the running window.

Test Plan:
- Basic: S=2, W=10, one pulse on ch0 at each of COUNT cycles 1, 5, 10, ch2 pulsed 4 times, out_ready=1 -> records (0,3),(1,0),(2,4),(3,0); out_last on ch3; done 1 cycle after; first out_valid exactly 13 cycles after start.
- Edges: pulse on ch1 in the last SETTLE cycle and the cycle after the last COUNT cycle -> ch1 count 0; pulse in the first and last COUNT cycles -> count 2.
- Backpressure: out_ready toggled 0,0,1,0,1,1,... -> each record held stable while stalled; order 0..3 preserved; no record lost or duplicated.
- Saturation: CNT_W=4, W=20, ch3 pulsed every COUNT cycle -> out_data=15, out_sat=1 for ch3 only.
- Zero window: S=0, W=0 -> out_valid rises the cycle after start; all counts 0. start while busy -> ignored (busy, done count unchanged).
- Abort/reset: abort during COUNT and during DRAIN (ch1 stalled) -> IDLE next cycle, no done, out_valid=0. rst_n pulsed low mid-COUNT -> outputs 0 asynchronously; a following clean run reports fresh counts.
